// File: rtl/mem_io_pkg.sv
// Shared decode constants and access classification for the CPU byte-bus responder.
package mem_io_pkg;

  localparam logic [31:0] IO_PORT_UART = 32'h30000;
  localparam logic [31:0] IO_PORT_CLK  = 32'h30004;

  localparam logic [1:0] REGION_IO  = 2'b11;
  localparam logic [1:0] REGION_BAD = 2'b10;

  typedef enum logic [2:0] {
    RAM_RD,
    RAM_WR,
    IO_RD_UART,
    IO_RD_CLK,
    IO_RD_SNAP,
    IO_WR_UART,
    IO_WR_STOP,
    NONE
  } access_t;

  // Little-endian byte of the counter snapshot; byte 0 is returned live by the latching read.
  function automatic logic [7:0] snap_byte(input logic [31:0] snap, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd1:    b = snap[15:8];
      2'd2:    b = snap[23:16];
      2'd3:    b = snap[31:24];
      default: b = snap[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Circular byte FIFO buffering UART TX; a push into a full FIFO succeeds only when a pop frees a slot that cycle.
module io_tx_fifo
  #(
    parameter int WIDTH = 3,
    parameter int SIZE  = 8
  )
  (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       head_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH:0]   count
  );

  localparam logic [WIDTH:0] SIZE_C = (WIDTH+1)'(SIZE);

  logic [7:0]       mem [0:(1<<WIDTH)-1];
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == SIZE_C);
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[head];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; emptied pointers make stale bytes unreachable.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[tail] <= push_data;
  end

endmodule

// File: rtl/mem_io_responder.sv
// Target end of the CPU byte bus: byte RAM plus UART/counter/stop IO, one-cycle registered read data.
module mem_io_responder
  import mem_io_pkg::*;
  #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_FIFO_WIDTH  = 3,
    parameter int TX_FIFO_SIZE   = 8,
    parameter     INIT_FILE      = "test.data"
  )
  (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic        program_stop
  );

  // Headroom of two slots covers CPU writes already in flight when full is seen.
  localparam logic [TX_FIFO_WIDTH:0] NEAR_FULL = (TX_FIFO_WIDTH+1)'(TX_FIFO_SIZE - 2);

  access_t                   access;
  logic [17:0]               io_addr;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic                      unused_a;

  logic [7:0]  ram [0:(1<<RAM_ADDR_WIDTH)-1];
  logic [7:0]  ram_q;
  logic        ram_sel;
  logic [7:0]  io_q;
  logic [31:0] counter;
  logic [31:0] snapshot;

  logic                     tx_push;
  logic [7:0]               tx_push_data;
  logic                     tx_empty;
  logic                     tx_full;
  logic [TX_FIFO_WIDTH:0]   tx_count;

  assign io_addr  = cpu_a[17:0];
  assign ram_idx  = cpu_a[RAM_ADDR_WIDTH-1:0];
  assign unused_a = ^cpu_a[31:18];

  always_comb begin
    access = NONE;
    case (cpu_a[17:16])
      REGION_IO: begin
        if (cpu_wr) begin
          if (io_addr == IO_PORT_UART[17:0])     access = IO_WR_UART;
          else if (io_addr == IO_PORT_CLK[17:0]) access = IO_WR_STOP;
        end else begin
          if (io_addr == IO_PORT_UART[17:0])     access = IO_RD_UART;
          else if (io_addr == IO_PORT_CLK[17:0]) access = IO_RD_CLK;
          else if (io_addr[17:2] == IO_PORT_CLK[17:2]) access = IO_RD_SNAP;
        end
      end
      REGION_BAD: access = NONE;
      default:    access = cpu_wr ? RAM_WR : RAM_RD;
    endcase
  end

  // A zero byte is the CPU's no-op for the UART port; the stop write emits 0x00 deliberately.
  assign tx_push      = ((access == IO_WR_UART) && (cpu_dout != 8'h00)) || (access == IO_WR_STOP);
  assign tx_push_data = (access == IO_WR_STOP) ? 8'h00 : cpu_dout;

  io_tx_fifo #(
    .WIDTH (TX_FIFO_WIDTH),
    .SIZE  (TX_FIFO_SIZE)
  ) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (uart_tx_ready),
    .head_data (uart_tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  assign uart_tx_valid  = ~tx_empty;
  assign io_buffer_full = (tx_count >= NEAR_FULL);

  always_ff @(posedge clk_in) begin
    if (access == RAM_WR) ram[ram_idx] <= cpu_dout;
    ram_q <= ram[ram_idx];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ram_sel       <= 1'b0;
      io_q          <= 8'h00;
      uart_rx_ready <= 1'b0;
      program_stop  <= 1'b0;
      counter       <= 32'h0;
      snapshot      <= 32'h0;
    end else begin
      counter       <= counter + 32'd1;
      ram_sel       <= (access == RAM_RD);
      io_q          <= 8'h00;
      uart_rx_ready <= 1'b0;
      case (access)
        IO_RD_UART: begin
          if (uart_rx_valid) begin
            io_q          <= uart_rx_data;
            uart_rx_ready <= 1'b1;
          end
        end
        IO_RD_CLK: begin
          snapshot <= counter;
          io_q     <= counter[7:0];
        end
        IO_RD_SNAP: io_q <= snap_byte(snapshot, io_addr[1:0]);
        IO_WR_STOP: program_stop <= 1'b1;
        default: ;
      endcase
    end
  end

  // Both sources are registers; the select keeps X from unread RAM off the bus after reset.
  assign cpu_din = ram_sel ? ram_q : io_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder against a queue/array reference model.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic        program_stop;

  int          checks   = 0;
  int          failures = 0;
  int unsigned edges    = 0;
  logic [7:0]  emitted [$];
  logic [7:0]  ram_m [int unsigned];

  localparam logic [31:0] UART = 32'h30000;
  localparam logic [31:0] CLKP = 32'h30004;
  localparam logic [31:0] IDLE = 32'h20000;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .cpu_a          (cpu_a),
    .cpu_wr         (cpu_wr),
    .cpu_dout       (cpu_dout),
    .cpu_din        (cpu_din),
    .io_buffer_full (io_buffer_full),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_valid  (uart_tx_valid),
    .uart_tx_ready  (uart_tx_ready),
    .uart_rx_data   (uart_rx_data),
    .uart_rx_valid  (uart_rx_valid),
    .uart_rx_ready  (uart_rx_ready),
    .program_stop   (program_stop)
  );

  always #5 clk_in = ~clk_in;

  // Clock edges since reset release: the value the cycle counter must hold.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) edges = 0;
    else        edges++;
  end

  always @(posedge clk_in) begin
    if (!rst_in && uart_tx_valid && uart_tx_ready) emitted.push_back(uart_tx_data);
  end

  task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
    cpu_a = a; cpu_wr = wr; cpu_dout = d;
    @(posedge clk_in); #1;
    cpu_a = IDLE; cpu_wr = 1'b0; cpu_dout = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) bus(IDLE, 1'b0, 8'h00);
  endtask

  task automatic test_reset;
    rst_in = 1'b1; cpu_a = IDLE; cpu_wr = 1'b0; cpu_dout = 8'h00;
    uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = 8'h00;
    #12;
    checks++; if (cpu_din !== 8'h00) begin failures++; $display("FAIL rst_cpu_din got=%0h exp=0", cpu_din); end
    checks++; if (uart_tx_valid !== 1'b0) begin failures++; $display("FAIL rst_tx_valid got=%0b exp=0", uart_tx_valid); end
    checks++; if (io_buffer_full !== 1'b0) begin failures++; $display("FAIL rst_buf_full got=%0b exp=0", io_buffer_full); end
    checks++; if (program_stop !== 1'b0) begin failures++; $display("FAIL rst_stop got=%0b exp=0", program_stop); end
    checks++; if (uart_rx_ready !== 1'b0) begin failures++; $display("FAIL rst_rx_ready got=%0b exp=0", uart_rx_ready); end
    @(negedge clk_in); rst_in = 1'b0;
    @(posedge clk_in); #1;
    bus(CLKP + 32'd3, 1'b0, 8'h00);
    checks++; if (cpu_din !== 8'h00) begin failures++; $display("FAIL rst_snapshot got=%0h exp=0", cpu_din); end
  endtask

  task automatic test_ram;
    logic [31:0] a;
    logic [7:0]  d;
    bus(32'h10, 1'b1, 8'hA5); ram_m[32'h10] = 8'hA5;
    bus(32'h10, 1'b0, 8'h00);
    checks++; if (cpu_din !== 8'hA5) begin failures++; $display("FAIL ram_a5 got=%0h exp=a5", cpu_din); end
    idle(1);
    checks++; if (cpu_din !== 8'h00) begin failures++; $display("FAIL ram_latency got=%0h exp=0", cpu_din); end
    for (int i = 0; i < 24; i++) begin
      a = {$urandom} & 32'hFFFC_0000 | 32'($urandom_range(0, 32'h1FFFF));
      d = 8'($urandom);
      bus(a, 1'b1, d);
      ram_m[a & 32'h1FFFF] = d;
      if ($urandom_range(0, 1) == 1) begin
        bus(a, 1'b0, 8'h00);
        checks++; if (cpu_din !== d) begin failures++; $display("FAIL ram_raw a=%0h got=%0h exp=%0h", a, cpu_din, d); end
      end
    end
    foreach (ram_m[k]) begin
      bus(k, 1'b0, 8'h00);
      checks++; if (cpu_din !== ram_m[k]) begin failures++; $display("FAIL ram_rd a=%0h got=%0h exp=%0h", k, cpu_din, ram_m[k]); end
    end
    bus(32'h20010, 1'b1, 8'h3C);
    bus(32'h20010, 1'b0, 8'h00);
    checks++; if (cpu_din !== 8'h00) begin failures++; $display("FAIL unmapped_rd got=%0h exp=0", cpu_din); end
    bus(32'hABC0_0010, 1'b0, 8'h00);
    checks++; if (cpu_din !== ram_m[32'h10]) begin failures++; $display("FAIL unmapped_wr got=%0h exp=%0h", cpu_din, ram_m[32'h10]); end
  endtask

  task automatic test_tx;
    logic [7:0] exp_q [$];
    logic [7:0] d;
    uart_tx_ready = 1'b1;
    emitted.delete();
    bus(UART, 1'b1, 8'h41);
    bus(UART, 1'b1, 8'h00);
    bus(UART, 1'b1, 8'h42);
    idle(4);
    checks++; if (emitted.size() != 2) begin failures++; $display("FAIL tx_basic_len got=%0d exp=2", emitted.size()); end
    else begin
      checks++; if (emitted[0] !== 8'h41 || emitted[1] !== 8'h42)
        begin failures++; $display("FAIL tx_basic_data got=%0h,%0h exp=41,42", emitted[0], emitted[1]); end
    end
    emitted.delete();
    for (int i = 0; i < 20; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      bus(UART, 1'b1, d);
      if (d != 8'h00) exp_q.push_back(d);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(6);
    checks++; if (emitted.size() != exp_q.size()) begin failures++; $display("FAIL tx_rand_len got=%0d exp=%0d", emitted.size(), exp_q.size()); end
    else begin
      foreach (exp_q[i]) begin
        checks++; if (emitted[i] !== exp_q[i]) begin failures++; $display("FAIL tx_rand_data i=%0d got=%0h exp=%0h", i, emitted[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_full;
    logic exp_full;
    uart_tx_ready = 1'b0;
    emitted.delete();
    for (int i = 1; i <= 7; i++) begin
      bus(UART, 1'b1, 8'h55);
      exp_full = (i >= 6);
      checks++; if (io_buffer_full !== exp_full) begin failures++; $display("FAIL near_full push=%0d got=%0b exp=%0b", i, io_buffer_full, exp_full); end
    end
    bus(UART, 1'b1, 8'h55);
    bus(UART, 1'b1, 8'h55);
    uart_rx_valid = 1'b1; uart_rx_data = 8'h7E;
    bus(UART, 1'b0, 8'h00);
    checks++; if (cpu_din !== 8'h7E) begin failures++; $display("FAIL rx_data got=%0h exp=7e", cpu_din); end
    checks++; if (uart_rx_ready !== 1'b1) begin failures++; $display("FAIL rx_pulse got=%0b exp=1", uart_rx_ready); end
    idle(1);
    checks++; if (uart_rx_ready !== 1'b0) begin failures++; $display("FAIL rx_single got=%0b exp=0", uart_rx_ready); end
    uart_rx_valid = 1'b0;
    uart_tx_ready = 1'b1;
    bus(UART, 1'b1, 8'h66);
    checks++; if (io_buffer_full !== 1'b1) begin failures++; $display("FAIL full_pushpop got=%0b exp=1", io_buffer_full); end
    idle(12);
    checks++; if (emitted.size() != 9) begin failures++; $display("FAIL full_len got=%0d exp=9", emitted.size()); end
    else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (emitted[i] !== ((i == 8) ? 8'h66 : 8'h55))
          begin failures++; $display("FAIL full_data i=%0d got=%0h", i, emitted[i]); end
      end
    end
    checks++; if (io_buffer_full !== 1'b0) begin failures++; $display("FAIL full_drain got=%0b exp=0", io_buffer_full); end
  endtask

  task automatic test_uart_rx;
    logic       v;
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      v = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      uart_rx_valid = v; uart_rx_data = d;
      bus(UART, 1'b0, 8'h00);
      checks++; if (cpu_din !== (v ? d : 8'h00)) begin failures++; $display("FAIL rx_rand v=%0b got=%0h exp=%0h", v, cpu_din, v ? d : 8'h00); end
      checks++; if (uart_rx_ready !== v) begin failures++; $display("FAIL rx_rand_pulse got=%0b exp=%0b", uart_rx_ready, v); end
    end
    uart_rx_valid = 1'b0;
  endtask

  task automatic test_counter;
    int unsigned exp;
    logic [31:0] got;
    for (int r = 0; r < 2; r++) begin
      exp = edges;
      bus(CLKP, 1'b0, 8'h00);
      got[7:0] = cpu_din;
      checks++; if (cpu_din !== exp[7:0]) begin failures++; $display("FAIL cnt_byte0 got=%0h exp=%0h", cpu_din, exp[7:0]); end
      idle($urandom_range(280, 320));
      bus(CLKP + 32'd1, 1'b0, 8'h00); got[15:8]  = cpu_din;
      bus(CLKP + 32'd2, 1'b0, 8'h00); got[23:16] = cpu_din;
      bus(CLKP + 32'd3, 1'b0, 8'h00); got[31:24] = cpu_din;
      checks++; if (got !== exp) begin failures++; $display("FAIL cnt_snapshot got=%0h exp=%0h", got, exp); end
    end
  endtask

  task automatic test_stop;
    uart_tx_ready = 1'b1;
    emitted.delete();
    checks++; if (program_stop !== 1'b0) begin failures++; $display("FAIL stop_pre got=%0b exp=0", program_stop); end
    bus(CLKP, 1'b1, 8'h01);
    checks++; if (program_stop !== 1'b1) begin failures++; $display("FAIL stop_set got=%0b exp=1", program_stop); end
    idle(3);
    checks++; if (emitted.size() != 1 || emitted[0] !== 8'h00)
      begin failures++; $display("FAIL stop_tx len=%0d exp=1 byte 00", emitted.size()); end
    bus(32'h1234, 1'b1, 8'h5A);
    bus(32'h1234, 1'b0, 8'h00);
    checks++; if (cpu_din !== 8'h5A) begin failures++; $display("FAIL stop_service got=%0h exp=5a", cpu_din); end
    checks++; if (program_stop !== 1'b1) begin failures++; $display("FAIL stop_sticky got=%0b exp=1", program_stop); end
    uart_tx_ready = 1'b0;
    bus(UART, 1'b1, 8'h11);
    bus(UART, 1'b1, 8'h22);
    bus(32'h1234, 1'b0, 8'h00);
    checks++; if (uart_tx_valid !== 1'b1) begin failures++; $display("FAIL pre_rst_valid got=%0b exp=1", uart_tx_valid); end
    #2; rst_in = 1'b1; #1;
    checks++; if (program_stop !== 1'b0) begin failures++; $display("FAIL async_rst_stop got=%0b exp=0", program_stop); end
    checks++; if (uart_tx_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%0b exp=0", uart_tx_valid); end
    checks++; if (cpu_din !== 8'h00) begin failures++; $display("FAIL async_rst_din got=%0h exp=0", cpu_din); end
    @(negedge clk_in); rst_in = 1'b0;
    @(posedge clk_in); #1;
    idle(2);
    checks++; if (uart_tx_valid !== 1'b0 || program_stop !== 1'b0)
      begin failures++; $display("FAIL post_rst valid=%0b stop=%0b exp=0,0", uart_tx_valid, program_stop); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_tx();
    test_full();
    test_uart_rx();
    test_counter();
    test_stop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
